// File: rtl/exu_adder_pkg.sv
// Shared types for the EXU adder datapath and the units that arbitrate access to it.
package exu_adder_pkg;

  localparam int ADDER_OP_W = 3;

  typedef enum logic [ADDER_OP_W-1:0] {
    OP_ADD   = 3'd0,
    OP_SUB   = 3'd1,
    OP_SLT   = 3'd2,
    OP_SLTU  = 3'd3,
    OP_AUIPC = 3'd4
  } adder_op_e;

endpackage

// File: rtl/exu_rr_arbiter.sv
// Round-robin arbiter: one-hot grant searched from last_ptr+1; pointer moves only on an accepted grant.
module exu_rr_arbiter #(
  parameter int N = 3,
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req_i,
  input  logic             advance_i,
  output logic [N-1:0]     grant_o,
  output logic [IDX_W-1:0] grant_idx_o
);

  logic [IDX_W-1:0] last_ptr_q;
  logic             found;
  int               idx;

  // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    grant_o     = '0;
    grant_idx_o = '0;
    found       = 1'b0;
    idx         = 0;
    for (int i = 0; i < N; i++) begin
      idx = (int'(last_ptr_q) + 1 + i) % N;
      if (!found && req_i[idx]) begin
        grant_o[idx] = 1'b1;
        grant_idx_o  = IDX_W'(idx);
        found        = 1'b1;
      end
    end
  end

  // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_ptr_q <= IDX_W'(N - 1);
    end else if (advance_i && found) begin
      last_ptr_q <= grant_idx_o;
    end
  end

endmodule

// File: rtl/exu_adder_arbiter.sv
// Shares one EXU adder between NUM_REQ requesters; the granted result is registered into a one-entry tagged response slot.
module exu_adder_arbiter
  import exu_adder_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int TAG_W   = 4,
  localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  flush_i,
  input  logic [NUM_REQ-1:0]                    req_valid_i,
  output logic [NUM_REQ-1:0]                    req_ready_o,
  input  logic [NUM_REQ-1:0][ADDER_OP_W-1:0]    req_op_i,
  input  logic [NUM_REQ-1:0][31:0]              req_op1_i,
  input  logic [NUM_REQ-1:0][31:0]              req_op2_i,
  input  logic [NUM_REQ-1:0][TAG_W-1:0]         req_tag_i,
  output logic [31:0]                           adder_op1_o,
  output logic [31:0]                           adder_op2_o,
  output logic                                  adder_add_o,
  output logic                                  adder_sub_o,
  output logic                                  adder_slt_o,
  output logic                                  adder_sltu_o,
  output logic                                  adder_auipc_o,
  input  logic [31:0]                           add_result_i,
  input  logic [31:0]                           sub_result_i,
  input  logic [31:0]                           slt_result_i,
  input  logic [31:0]                           sltu_result_i,
  input  logic [31:0]                           auipc_result_i,
  output logic                                  rsp_valid_o,
  input  logic                                  rsp_ready_i,
  output logic [NUM_REQ-1:0]                    rsp_src_o,
  output logic [TAG_W-1:0]                      rsp_tag_o,
  output logic [31:0]                           rsp_data_o
);

  logic                  slot_free, can_grant, accept;
  logic [NUM_REQ-1:0]    grant;
  logic [IDX_W-1:0]      win_idx;
  logic [ADDER_OP_W-1:0] win_op;
  logic [31:0]           result;

  logic                  rsp_valid_q, rsp_valid_d;
  logic [NUM_REQ-1:0]    rsp_src_q, rsp_src_d;
  logic [TAG_W-1:0]      rsp_tag_q, rsp_tag_d;
  logic [31:0]           rsp_data_q, rsp_data_d;

  // Slot drains and refills in the same cycle; flush blocks any grant.
  assign slot_free   = ~rsp_valid_q | rsp_ready_i;
  assign can_grant   = slot_free & ~flush_i;
  assign accept      = can_grant & (|grant);
  assign req_ready_o = can_grant ? grant : '0;
  assign win_op      = req_op_i[win_idx];

  exu_rr_arbiter #(.N(NUM_REQ)) u_arb (
    .clk         (clk),
    .rst         (rst),
    .req_i       (req_valid_i),
    .advance_i   (can_grant),
    .grant_o     (grant),
    .grant_idx_o (win_idx)
  );

  // Adder stays quiescent unless a request is actually accepted; illegal codes raise no flag and yield 0.
  always_comb begin
    adder_op1_o   = '0;
    adder_op2_o   = '0;
    adder_add_o   = 1'b0;
    adder_sub_o   = 1'b0;
    adder_slt_o   = 1'b0;
    adder_sltu_o  = 1'b0;
    adder_auipc_o = 1'b0;
    result        = '0;
    if (accept) begin
      adder_op1_o = req_op1_i[win_idx];
      adder_op2_o = req_op2_i[win_idx];
      case (win_op)
        OP_ADD:   begin adder_add_o   = 1'b1; result = add_result_i;   end
        OP_SUB:   begin adder_sub_o   = 1'b1; result = sub_result_i;   end
        OP_SLT:   begin adder_slt_o   = 1'b1; result = slt_result_i;   end
        OP_SLTU:  begin adder_sltu_o  = 1'b1; result = sltu_result_i;  end
        OP_AUIPC: begin adder_auipc_o = 1'b1; result = auipc_result_i; end
        default:  ;
      endcase
    end
  end

  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_src_d   = rsp_src_q;
    rsp_tag_d   = rsp_tag_q;
    rsp_data_d  = rsp_data_q;
    if (accept) begin
      rsp_valid_d = 1'b1;
      rsp_src_d   = grant;
      rsp_tag_d   = req_tag_i[win_idx];
      rsp_data_d  = result;
    end else if (rsp_ready_i || flush_i) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid_q <= 1'b0;
      rsp_src_q   <= '0;
      rsp_tag_q   <= '0;
      rsp_data_q  <= '0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_src_q   <= rsp_src_d;
      rsp_tag_q   <= rsp_tag_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign rsp_valid_o = rsp_valid_q;
  assign rsp_src_o   = rsp_src_q;
  assign rsp_tag_o   = rsp_tag_q;
  assign rsp_data_o  = rsp_data_q;

endmodule

// File: tb/tb_exu_adder_arbiter.sv
// Directed bench for exu_adder_arbiter: expected responses are queued at issue and checked by an independent monitor.
module tb_exu_adder_arbiter;

  logic              clk = 1'b0;
  logic              rst;
  logic              flush_i;
  logic [2:0]        req_valid;
  logic [2:0]        req_ready;
  logic [2:0][2:0]   req_op;
  logic [2:0][31:0]  req_op1, req_op2;
  logic [2:0][3:0]   req_tag;
  logic [31:0]       adder_op1, adder_op2;
  logic              f_add, f_sub, f_slt, f_sltu, f_auipc;
  logic [31:0]       add_res, sub_res, slt_res, sltu_res, auipc_res;
  logic              rsp_valid, rsp_ready;
  logic [2:0]        rsp_src;
  logic [3:0]        rsp_tag;
  logic [31:0]       rsp_data;
  logic [4:0]        flags;

  typedef struct packed {
    logic [2:0]  src;
    logic [3:0]  tag;
    logic [31:0] data;
  } rsp_t;

  rsp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  // External adder model driven by the DUT's operand outputs.
  assign add_res   = adder_op1 + adder_op2;
  assign sub_res   = adder_op1 - adder_op2;
  assign slt_res   = {31'b0, $signed(adder_op1) < $signed(adder_op2)};
  assign sltu_res  = {31'b0, adder_op1 < adder_op2};
  assign auipc_res = adder_op1 + adder_op2;
  assign flags     = {f_auipc, f_sltu, f_slt, f_sub, f_add};

  exu_adder_arbiter #(.NUM_REQ(3), .TAG_W(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .flush_i        (flush_i),
    .req_valid_i    (req_valid),
    .req_ready_o    (req_ready),
    .req_op_i       (req_op),
    .req_op1_i      (req_op1),
    .req_op2_i      (req_op2),
    .req_tag_i      (req_tag),
    .adder_op1_o    (adder_op1),
    .adder_op2_o    (adder_op2),
    .adder_add_o    (f_add),
    .adder_sub_o    (f_sub),
    .adder_slt_o    (f_slt),
    .adder_sltu_o   (f_sltu),
    .adder_auipc_o  (f_auipc),
    .add_result_i   (add_res),
    .sub_result_i   (sub_res),
    .slt_result_i   (slt_res),
    .sltu_result_i  (sltu_res),
    .auipc_result_i (auipc_res),
    .rsp_valid_o    (rsp_valid),
    .rsp_ready_i    (rsp_ready),
    .rsp_src_o      (rsp_src),
    .rsp_tag_o      (rsp_tag),
    .rsp_data_o     (rsp_data)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: flushed responses are discarded, handshaken ones compared against the queue head.
  always @(negedge clk) begin
    if (!rst && rsp_valid === 1'b1 && (flush_i || rsp_ready)) begin
      if (sb.size() == 0) begin
        check("rsp_unexpected", 32'd1, 32'd0);
      end else begin
        rsp_t e;
        e = sb.pop_front();
        if (!flush_i) begin
          check("rsp_src", 32'(rsp_src), 32'(e.src));
          check("rsp_tag", 32'(rsp_tag), 32'(e.tag));
          check("rsp_data", rsp_data, e.data);
        end
      end
    end
  end

  function automatic rsp_t mk(input int idx, input logic [3:0] tag, input logic [31:0] data);
    rsp_t r;
    r.src  = 3'(1 << idx);
    r.tag  = tag;
    r.data = data;
    return r;
  endfunction

  task automatic set_req(input int idx, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [3:0] tag);
    req_op[idx]  = op;
    req_op1[idx] = a;
    req_op2[idx] = b;
    req_tag[idx] = tag;
  endtask

  // Single-requester transaction: checks same-cycle grant and adder drive, queues the response.
  task automatic issue(input int idx, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] tag, input logic [31:0] exp_data, input logic [4:0] exp_flags,
                       input logic rdy);
    set_req(idx, op, a, b, tag);
    req_valid = 3'(1 << idx);
    rsp_ready = rdy;
    @(negedge clk);
    check("req_ready", 32'(req_ready), 32'(1 << idx));
    check("adder_flags", 32'(flags), 32'(exp_flags));
    check("adder_op1", adder_op1, a);
    check("adder_op2", adder_op2, b);
    sb.push_back(mk(idx, tag, exp_data));
    @(posedge clk); #1;
    req_valid = '0;
  endtask

  task automatic idle(input int n);
    req_valid = '0;
    rsp_ready = 1'b1;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #3;
    check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset_rsp_data", rsp_data, 32'd0);
    check("reset_rsp_tag", 32'(rsp_tag), 32'd0);
    check("reset_rsp_src", 32'(rsp_src), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [2:0]  exp_win [6] = '{0, 1, 2, 0, 1, 2};
    logic [31:0] exp_dat [3] = '{32'd3, 32'd6, 32'h0000_1020};
    logic [3:0]  exp_tg  [3] = '{4'd1, 4'd2, 4'd5};

    flush_i = 1'b0; req_valid = '0; rsp_ready = 1'b1;
    req_op = '0; req_op1 = '0; req_op2 = '0; req_tag = '0;
    do_reset();

    // First transaction: result appears the cycle after acceptance.
    issue(0, 3'd0, 32'd5, 32'd7, 4'd3, 32'd12, 5'b00001, 1'b1);
    @(negedge clk);
    check("latency_rsp_valid", 32'(rsp_valid), 32'd1);
    @(posedge clk); #1;

    // All three valid continuously: grants rotate 0,1,2,0,1,2 after reset.
    do_reset();
    set_req(0, 3'd0, 32'd1, 32'd2, 4'd1);
    set_req(1, 3'd1, 32'd10, 32'd4, 4'd2);
    set_req(2, 3'd4, 32'h0000_1000, 32'h20, 4'd5);
    req_valid = 3'b111;
    rsp_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("rr_grant", 32'(req_ready), 32'(1 << exp_win[i]));
      sb.push_back(mk(int'(exp_win[i]), exp_tg[exp_win[i]], exp_dat[exp_win[i]]));
      @(posedge clk); #1;
    end
    req_valid = '0;

    // Signed vs unsigned compare and negative subtraction.
    issue(1, 3'd2, 32'hFFFF_FFFF, 32'd1, 4'hA, 32'd1, 5'b00100, 1'b1);
    issue(1, 3'd3, 32'hFFFF_FFFF, 32'd1, 4'hB, 32'd0, 5'b01000, 1'b1);
    issue(1, 3'd1, 32'd3, 32'd5, 4'hC, 32'hFFFF_FFFE, 5'b00010, 1'b1);

    // Backpressure: full slot blocks req2 and holds the payload.
    idle(1);
    issue(0, 3'd0, 32'd100, 32'd23, 4'd7, 32'd123, 5'b00001, 1'b0);
    set_req(2, 3'd3, 32'd2, 32'd3, 4'd9);
    req_valid = 3'b100;
    rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("bp_ready", 32'(req_ready), 32'd0);
      check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      check("bp_rsp_data", rsp_data, 32'd123);
      check("bp_rsp_tag", 32'(rsp_tag), 32'd7);
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    check("bp_release_ready", 32'(req_ready), 32'b100);
    sb.push_back(mk(2, 4'd9, 32'd1));
    @(posedge clk); #1;
    req_valid = '0;

    // Flush with full slot: no grant, slot cleared, pointer (at 0) unchanged.
    idle(1);
    issue(0, 3'd0, 32'd1, 32'd1, 4'd4, 32'd2, 5'b00001, 1'b0);
    set_req(0, 3'd0, 32'd20, 32'd1, 4'd1);
    set_req(1, 3'd0, 32'd30, 32'd2, 4'd2);
    set_req(2, 3'd0, 32'd40, 32'd3, 4'd3);
    req_valid = 3'b011;
    flush_i = 1'b1;
    rsp_ready = 1'b1;
    @(negedge clk);
    check("flush_ready", 32'(req_ready), 32'd0);
    check("flush_flags", 32'(flags), 32'd0);
    check("flush_op1", adder_op1, 32'd0);
    @(posedge clk); #1;
    flush_i = 1'b0;
    req_valid = 3'b111;
    @(negedge clk);
    check("post_flush_rsp_valid", 32'(rsp_valid), 32'd0);
    check("post_flush_grant", 32'(req_ready), 32'b010);
    sb.push_back(mk(1, 4'd2, 32'd32));
    @(posedge clk); #1;
    req_valid = '0;

    // Illegal op code 6: accepted, no adder flag, zero result.
    issue(0, 3'd6, 32'd5, 32'd9, 4'd2, 32'd0, 5'b00000, 1'b1);
    idle(1);

    // Asynchronous reset with a full slot: valid drops before any clock edge.
    issue(2, 3'd0, 32'd8, 32'd8, 4'd6, 32'd16, 5'b00001, 1'b0);
    #2;
    check("pre_rst_rsp_valid", 32'(rsp_valid), 32'd1);
    rst = 1'b1;
    #1;
    check("async_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("async_rst_rsp_data", rsp_data, 32'd0);
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    idle(2);

    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
